// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection light controller and its emergency
// request arbiter: direction codes, arbiter states and the counter width.
package traffic_pkg;

    localparam int CNT_W = 24;

    typedef enum logic [1:0] {
        DIR_N = 2'b00,
        DIR_E = 2'b01,
        DIR_S = 2'b10,
        DIR_W = 2'b11
    } dir_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // Round-robin pick: first set bit at ptr+1, ptr+2, ptr+3, ptr+4 (mod 4).
    function automatic dir_e rr_pick(input logic [3:0] req, input dir_e ptr);
        logic [1:0] base;
        logic [1:0] idx;
        dir_e       pick;
        base = ptr;
        pick = ptr;
        for (int i = 4; i >= 1; i--) begin
            idx = base + 2'(i);
            if (req[idx]) begin
                pick = dir_e'(idx);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/debounce_filter.sv
// One detector line: two-flop synchronizer followed by a consecutive-mismatch
// counter that flips the filtered value only after a sustained change.
module debounce_filter
    import traffic_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic filtered_o
);

    logic             sync1_q;
    logic             sync2_q;
    logic             filt_q;
    logic             filt_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    // Any cycle of agreement restarts the count, so only unbroken runs flip.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                filt_d = ~filt_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign filtered_o = filt_q;

endmodule

// File: rtl/emergency_request_arbiter.sv
// Debounces four emergency detector lines and grants one approach at a time,
// round-robin, holding each grant for a guaranteed minimum number of cycles.
module emergency_request_arbiter
    import traffic_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned MIN_HOLD_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req_raw,
    output logic       emergency,
    output logic [1:0] emg_dir,
    output logic [3:0] req_filtered
);

    logic [3:0]       filt_w;
    logic [3:0]       req_filtered_q;
    arb_state_e       state_q;
    arb_state_e       state_d;
    dir_e             emg_dir_q;
    dir_e             emg_dir_d;
    dir_e             last_grant_q;
    dir_e             last_grant_d;
    logic [CNT_W-1:0] hold_cnt_q;
    logic [CNT_W-1:0] hold_cnt_d;
    dir_e             pick;
    logic             any_req;
    logic             hold_done;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_filt
            debounce_filter #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_filt (
                .clk       (clk),
                .reset     (reset),
                .raw_i     (req_raw[gi]),
                .filtered_o(filt_w[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_filtered_q <= '0;
            state_q        <= ST_IDLE;
            emg_dir_q      <= DIR_N;
            last_grant_q   <= DIR_W;
            hold_cnt_q     <= '0;
        end else begin
            req_filtered_q <= filt_w;
            state_q        <= state_d;
            emg_dir_q      <= emg_dir_d;
            last_grant_q   <= last_grant_d;
            hold_cnt_q     <= hold_cnt_d;
        end
    end

    assign pick      = rr_pick(req_filtered_q, last_grant_q);
    assign any_req   = |req_filtered_q;
    assign hold_done = (hold_cnt_q >= CNT_W'(MIN_HOLD_CYCLES));

    always_comb begin
        state_d      = state_q;
        emg_dir_d    = emg_dir_q;
        last_grant_d = last_grant_q;
        hold_cnt_d   = hold_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d      = ST_GRANT;
                    emg_dir_d    = pick;
                    last_grant_d = pick;
                    hold_cnt_d   = '0;
                end
            end
            ST_GRANT: begin
                if (hold_done && !req_filtered_q[emg_dir_q]) begin
                    // Hand over directly to the next requester without a gap.
                    if (any_req) begin
                        emg_dir_d    = pick;
                        last_grant_d = pick;
                        hold_cnt_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (!hold_done) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        emergency    = (state_q == ST_GRANT);
        emg_dir      = emg_dir_q;
        req_filtered = req_filtered_q;
    end

endmodule

// File: tb/tb_emergency_request_arbiter.sv
// Directed bench for emergency_request_arbiter at default parameters; edge 0 is
// the first rising edge that samples a newly applied req_raw value.
module tb_emergency_request_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req_raw;
    logic       emergency;
    logic [1:0] emg_dir;
    logic [3:0] req_filtered;

    int n_checks = 0;
    int n_fails  = 0;
    int edge_n   = 0;
    logic ok;

    emergency_request_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .req_raw     (req_raw),
        .emergency   (emergency),
        .emg_dir     (emg_dir),
        .req_filtered(req_filtered)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, edge_n, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        @(negedge clk);
    endtask

    task automatic run_to(input int n);
        while (edge_n < n) tick();
    endtask

    task automatic do_reset();
        req_raw = 4'b0000;
        reset   = 1'b1;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset  = 1'b0;
        edge_n = -1;
    endtask

    initial begin
        reset   = 1'b1;
        req_raw = 4'b1111;

        // Reset held with all detectors active
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_emergency", {7'd0, emergency}, 8'h00);
            check("rst_emg_dir", {6'd0, emg_dir}, 8'h00);
            check("rst_req_filtered", {4'd0, req_filtered}, 8'h00);
        end
        reset  = 1'b0;
        edge_n = -1;
        run_to(17);
        check("rst_filt_e17", {4'd0, req_filtered}, 8'h00);
        run_to(18);
        check("rst_filt_e18", {4'd0, req_filtered}, 8'h0F);
        check("rst_emg_e18", {7'd0, emergency}, 8'h00);
        run_to(19);
        check("rst_emg_e19", {7'd0, emergency}, 8'h01);
        check("rst_dir_e19", {6'd0, emg_dir}, 8'h00);
        $display("reset: first grant N at edge 19 checked");

        // Glitch rejection on E: 10 cycles high
        do_reset();
        req_raw = 4'b0010;
        ok = 1'b1;
        while (edge_n < 40) begin
            tick();
            if (edge_n == 9) req_raw = 4'b0000;
            if (req_filtered != 4'b0000 || emergency != 1'b0) ok = 1'b0;
        end
        check("glitch_quiet", {7'd0, ok}, 8'h01);
        $display("glitch: 10-cycle pulse on E observed for 40 edges");

        // Single S request with minimum hold
        do_reset();
        req_raw = 4'b0100;
        run_to(17);
        check("single_filt_e17", {4'd0, req_filtered}, 8'h00);
        run_to(18);
        check("single_filt_e18", {4'd0, req_filtered}, 8'h04);
        check("single_emg_e18", {7'd0, emergency}, 8'h00);
        run_to(19);
        check("single_emg_e19", {7'd0, emergency}, 8'h01);
        check("single_dir_e19", {6'd0, emg_dir}, 8'h02);
        run_to(29);
        req_raw = 4'b0000;
        run_to(47);
        check("single_filt_e47", {4'd0, req_filtered}, 8'h04);
        run_to(50);
        check("single_filt_e50", {4'd0, req_filtered}, 8'h00);
        run_to(83);
        check("single_emg_e83", {7'd0, emergency}, 8'h01);
        run_to(84);
        check("single_emg_e84", {7'd0, emergency}, 8'h00);
        check("single_dir_e84", {6'd0, emg_dir}, 8'h02);
        $display("single: S grant 19..83 checked");

        // Reset asserted mid-grant, request still held
        do_reset();
        req_raw = 4'b0100;
        run_to(19);
        check("midrst_emg_e19", {7'd0, emergency}, 8'h01);
        run_to(30);
        reset = 1'b1;
        #1;
        check("midrst_emg_async", {7'd0, emergency}, 8'h00);
        check("midrst_dir_async", {6'd0, emg_dir}, 8'h00);
        check("midrst_filt_async", {4'd0, req_filtered}, 8'h00);
        @(posedge clk);
        @(negedge clk);
        reset  = 1'b0;
        edge_n = -1;
        run_to(18);
        check("midrst_emg_e18", {7'd0, emergency}, 8'h00);
        check("midrst_filt_e18", {4'd0, req_filtered}, 8'h04);
        run_to(19);
        check("midrst_emg_e19b", {7'd0, emergency}, 8'h01);
        check("midrst_dir_e19b", {6'd0, emg_dir}, 8'h02);
        $display("mid-grant reset: drop and re-grant at edge 19 checked");

        // Simultaneous N and E, then N released
        do_reset();
        req_raw = 4'b0011;
        run_to(19);
        check("simul_emg_e19", {7'd0, emergency}, 8'h01);
        check("simul_dir_e19", {6'd0, emg_dir}, 8'h00);
        ok = 1'b1;
        while (edge_n < 121) begin
            if (edge_n == 99) req_raw = 4'b0010;
            tick();
            if (emergency != 1'b1) ok = 1'b0;
            if (edge_n == 117) check("simul_dir_e117", {6'd0, emg_dir}, 8'h00);
        end
        check("simul_dir_e121", {6'd0, emg_dir}, 8'h01);
        check("simul_no_gap", {7'd0, ok}, 8'h01);
        $display("simultaneous: N then E without gap checked");

        // Round-robin fairness after a completed W grant
        do_reset();
        req_raw = 4'b1000;
        run_to(19);
        check("rr_dir_w", {6'd0, emg_dir}, 8'h03);
        req_raw = 4'b0000;
        run_to(83);
        check("rr_emg_e83", {7'd0, emergency}, 8'h01);
        run_to(84);
        check("rr_emg_e84", {7'd0, emergency}, 8'h00);
        run_to(89);
        req_raw = 4'b0101;
        run_to(108);
        check("rr_emg_e108", {7'd0, emergency}, 8'h00);
        run_to(109);
        check("rr_emg_e109", {7'd0, emergency}, 8'h01);
        check("rr_dir_e109", {6'd0, emg_dir}, 8'h00);
        ok = 1'b1;
        while (edge_n < 222) begin
            if (edge_n == 199) req_raw = 4'b0100;
            tick();
            if (emergency != 1'b1) ok = 1'b0;
            if (edge_n == 216) check("rr_dir_e216", {6'd0, emg_dir}, 8'h00);
        end
        check("rr_dir_e222", {6'd0, emg_dir}, 8'h02);
        check("rr_no_gap", {7'd0, ok}, 8'h01);
        $display("round-robin: W, then N, then S without gap checked");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
